// File: rtl/rf_dump_32.sv
// Debug readout sequencer for rf_32. It borrows one read port through an external mux.
// It then streams (index, value) pairs from a wrapping index range over valid/ready.
module rf_dump_32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  rf_sel,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // state  | meaning
    // S_IDLE | waiting for start, read port released
    // S_READ | rf_addr settled, capture rf_data at the edge
    // S_SEND | word presented, hold until accepted
    // S_DONE | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   last_q, last_d;
    logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
    logic                    rf_sel_q, rf_sel_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        rf_addr_d   = rf_addr_q;
        rf_sel_d    = rf_sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                // rf_addr doubles as the latched first index
                if (start) begin
                    last_d    = last_addr;
                    rf_addr_d = first_addr;
                    rf_sel_d  = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                out_data_d  = rf_data;
                out_addr_d  = rf_addr_q;
                out_last_d  = (rf_addr_q == last_q);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        rf_sel_d = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        rf_addr_d = rf_addr_q + ADDR_WIDTH'(1);
                        state_d   = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rf_sel_d    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= '0;
            rf_addr_q   <= '0;
            rf_sel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            rf_addr_q   <= rf_addr_d;
            rf_sel_q    <= rf_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rf_sel    = rf_sel_q;
    assign rf_addr   = rf_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rf_dump_32.sv
// Bench for rf_dump_32: register file model, directed scenarios and random dumps
// checked against an index-range model of the expected word stream.
module tb_rf_dump_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, out_ready;
    logic [4:0]  first_addr, last_addr;
    logic        rf_sel, out_valid, out_last, busy, done;
    logic [4:0]  rf_addr, out_addr;
    logic [31:0] rf_data, out_data;

    logic [31:0] regs [32];
    assign rf_data = regs[rf_addr];

    always #5 clk = ~clk;

    rf_dump_32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_sel(rf_sel), .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed stream of one dump
    logic [4:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_cyc[$];
    int          done_cnt, start_cyc, first_valid_cyc;
    bit          stable_bad, timed_out, done_at_idle;

    // reference: expected words for a range
    logic [4:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];

    task automatic build_exp(input int f, input int l);
        int n;
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
        n = ((l - f) % 32 + 32) % 32 + 1;
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(5'((f + k) % 32));
            exp_data.push_back(regs[(f + k) % 32]);
            exp_last.push_back(k == n - 1);
        end
    endtask

    task automatic run_dump(input int f, input int l, input int ready_pct, input bit restart);
        logic [31:0] pd;
        logic [4:0]  pa;
        bit          pend;
        bit          prev_done;
        int          budget;
        obs_addr.delete(); obs_data.delete(); obs_last.delete(); obs_cyc.delete();
        done_cnt = 0; stable_bad = 0; timed_out = 0; first_valid_cyc = -1;
        pend = 0; prev_done = 0; budget = 0; pd = '0; pa = '0;
        @(negedge clk);
        first_addr = 5'(f); last_addr = 5'(l); start = 1'b1; out_ready = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (busy && budget < 600) begin
            if (done) done_cnt++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pend && out_valid && (out_data !== pd || out_addr !== pa)) stable_bad = 1;
            out_ready = ($urandom_range(99) < ready_pct);
            if (restart && $urandom_range(3) == 0) begin
                start = 1'b1;
                first_addr = 5'($urandom_range(31));
                last_addr = 5'($urandom_range(31));
            end else start = 1'b0;
            if (out_valid && out_ready) begin
                obs_addr.push_back(out_addr); obs_data.push_back(out_data);
                obs_last.push_back(out_last); obs_cyc.push_back(cyc);
                pend = 0;
            end else if (out_valid) begin
                pend = 1; pd = out_data; pa = out_addr;
            end
            prev_done = done;
            @(negedge clk);
            budget++;
        end
        timed_out = (budget >= 600);
        done_at_idle = prev_done;
        start = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; abort = 0; out_ready = 0; first_addr = 0; last_addr = 0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        #23;
        checks++;
        if ({rf_sel, rf_addr, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got sel=%b addr=%0d v=%b d=%h oa=%0d l=%b busy=%b done=%b want all 0",
                     rf_sel, rf_addr, out_valid, out_data, out_addr, out_last, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic;
        regs[2] = 32'h11111111; regs[3] = 32'h22222222;
        regs[4] = 32'h33333333; regs[5] = 32'h44444444;
        build_exp(2, 5);
        run_dump(2, 5, 100, 0);
        checks++;
        if (timed_out || obs_addr.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d timeout=%b want 4", obs_addr.size(), timed_out);
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL basic_word%0d got (%0d,%h,%b) want (%0d,%h,%b)", i,
                         obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], exp_last[i]);
            end
            if (i > 0) begin
                checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != 2) begin
                    errors++;
                    $display("FAIL basic_spacing%0d got %0d want 2", i, obs_cyc[i] - obs_cyc[i-1]);
                end
            end
        end
        checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want 2", first_valid_cyc - start_cyc);
        end
        checks++;
        if (done_cnt != 1 || !done_at_idle) begin
            errors++;
            $display("FAIL basic_done got pulses=%0d done_with_busy_fall=%b want 1 1", done_cnt, done_at_idle);
        end
    endtask

    task automatic test_wrap;
        regs[30] = 32'h0000000E; regs[31] = 32'hDEADBEEF;
        regs[0] = $urandom; regs[1] = $urandom;
        build_exp(30, 1);
        run_dump(30, 1, 100, 0);
        checks++;
        if (timed_out || obs_addr.size() != 4) begin
            errors++;
            $display("FAIL wrap_count got %0d want 4", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL wrap_word%0d got (%0d,%h,%b) want (%0d,%h,%b)", i,
                         obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_stall;
        int budget;
        regs[7] = 32'h66666666;
        @(negedge clk);
        first_addr = 5'd7; last_addr = 5'd7; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!out_valid && budget < 10) begin @(negedge clk); budget++; end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h66666666 || out_addr !== 5'd7 || out_last !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b d=%h a=%0d l=%b want 1 66666666 7 1",
                         k, out_valid, out_data, out_addr, out_last);
            end
            regs[7] = $urandom;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || rf_sel !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got done=%b valid=%b sel=%b want 1 0 0", done, out_valid, rf_sel);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_after got done=%b busy=%b valid=%b want 0 0 0 (single word)", done, busy, out_valid);
        end
    endtask

    task automatic test_restart;
        int bad;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        build_exp(0, 31);
        run_dump(0, 31, 70, 1);
        checks++;
        if (timed_out || obs_addr.size() != 32 || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_count got words=%0d done=%0d want 32 1", obs_addr.size(), done_cnt);
        end
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < 32; i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) bad++;
        checks++;
        if (bad != 0 || stable_bad) begin
            errors++;
            $display("FAIL restart_words got %0d bad words stable_bad=%b want 0 0", bad, stable_bad);
        end
    endtask

    task automatic test_abort;
        int hs, budget;
        bit saw;
        @(negedge clk);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; budget = 0;
        while (hs < 3 && budget < 50) begin
            if (out_valid && out_ready) hs++;
            @(negedge clk);
            budget++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (hs != 3 || busy !== 1'b0 || out_valid !== 1'b0 || rf_sel !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got hs=%0d busy=%b valid=%b sel=%b done=%b want 3 0 0 0 0",
                     hs, busy, out_valid, rf_sel, done);
        end
        saw = 0;
        repeat (5) begin @(negedge clk); if (done || busy) saw = 1; end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL abort_quiet got done/busy activity=1 want 0");
        end
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        build_exp(4, 9);
        run_dump(4, 9, 100, 0);
        checks++;
        if (timed_out || obs_addr.size() != 6 || done_cnt != 1 || obs_data[0] !== exp_data[0]
            || obs_addr[5] !== 5'd9 || obs_last[5] !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart got words=%0d done=%0d want 6 1", obs_addr.size(), done_cnt);
        end
    endtask

    task automatic test_async_reset;
        int budget;
        bit bad;
        @(negedge clk);
        first_addr = 5'd10; last_addr = 5'd12; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!out_valid && budget < 10) begin @(negedge clk); budget++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rf_sel, rf_addr, out_valid, out_data, out_addr, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset got sel=%b addr=%0d v=%b d=%h oa=%0d l=%b busy=%b done=%b want all 0",
                     rf_sel, rf_addr, out_valid, out_data, out_addr, out_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        repeat (4) begin @(negedge clk); if (busy || out_valid || rf_sel || done) bad = 1; end
        out_ready = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL async_idle got activity after release want idle");
        end
    endtask

    task automatic test_random;
        int f, l, pct, bad;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f = $urandom_range(31); l = $urandom_range(31); pct = $urandom_range(100, 30);
            build_exp(f, l);
            run_dump(f, l, pct, 0);
            bad = 0;
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) bad++;
            checks++;
            if (timed_out || obs_addr.size() != exp_addr.size() || bad != 0 || done_cnt != 1 || stable_bad) begin
                errors++;
                $display("FAIL random%0d f=%0d l=%0d got words=%0d bad=%0d done=%0d unstable=%b want %0d 0 1 0",
                         it, f, l, obs_addr.size(), bad, done_cnt, stable_bad, exp_addr.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_restart();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_dump_32.md
Name: rf_dump_32

Overview:
Debug readout sequencer that acts as the reader for rf_32. On a start pulse it takes over one rf_32 read port through an external mux driven by rf_sel. It walks a register index range and streams each (index, value) pair out over a valid/ready interface. It sits beside the CPU datapath and feeds a UART or debug scan path.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register index width; index space 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
abort  input  1  synchronous cancel; highest priority after reset
first_addr  input  ADDR_WIDTH  first register index, latched on accepted start
last_addr  input  ADDR_WIDTH  last register index, latched on accepted start
rf_sel  output  1  high while the block owns the rf_32 read port (mux select)
rf_addr  output  ADDR_WIDTH  register index driven to the rf_32 rs/rt port
rf_data  input  DATA_WIDTH  combinational rf_32 read data for rf_addr
out_valid  output  1  output word valid
out_ready  input  1  downstream accept
out_data  output  DATA_WIDTH  captured register value
out_addr  output  ADDR_WIDTH  index of out_data
out_last  output  1  high with the final word of the dump
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0 (rf_sel, rf_addr, out_valid, out_data, out_addr, out_last, busy, done); latched first/last cleared.
- States are IDLE, READ, SEND and DONE.
- IDLE:
  - start=1 latches first_addr and last_addr; rf_addr<=first_addr; rf_sel<=1; next state READ.
  - start is ignored in every other state.
- READ (one cycle):
  - rf_addr is stable.
  - At the clock edge: out_data<=rf_data; out_addr<=rf_addr; out_last<=(rf_addr==last latched); out_valid<=1; next state SEND.
- SEND: out_valid, out_data, out_addr and out_last hold stable until out_valid&&out_ready.
  - On handshake with out_last=1: out_valid<=0; rf_sel<=0; next state DONE.
  - On handshake with out_last=0: out_valid<=0; rf_addr<=rf_addr+1 modulo 2**ADDR_WIDTH; next state READ.
- DONE: done=1 for exactly one cycle; next state IDLE.
- Throughput: 2 cycles per word minimum (READ+SEND with out_ready held high).
  - Latency from accepted start to the first out_valid is 2 cycles.
- Word count = ((last-first) mod 2**ADDR_WIDTH)+1.
  - first==last yields exactly one word.
  - last<first wraps through index 31->0; e.g. first=30, last=1 yields indices 30,31,0,1.
- abort=1 in any non-IDLE state: next state IDLE; out_valid, out_last and rf_sel cleared; done is not pulsed. abort in IDLE has no effect.
- Concurrent rf_32 writes are permitted. The value captured is whatever rf_data holds at the READ-cycle edge; a write to rf_addr landing on that same edge is not guaranteed to be visible.
- rf_data is sampled only in READ; changes in rf_data during SEND do not alter out_data.
- Reset asserted mid-dump returns to IDLE immediately with all outputs 0. No partial handshake completes.

Test Plan:
- Preload regs 2..5 = 11111111, 22222222, 33333333, 44444444; start with first=2, last=5, out_ready=1.
  -> words (2,11111111), (3,22222222), (4,33333333), (5,44444444) on consecutive 2-cycle slots; out_last only with index 5; done pulses once; busy falls together with done.
- first=30, last=1 with reg30=0000000E, reg31=DEADBEEF.
  -> indices 30,31,0,1 in order with correct data; out_last on index 1.
- first=last=7 with reg7=66666666, and out_ready held low for 5 cycles after out_valid rises.
  -> out_valid and out_data=66666666 stay stable for all 5 stall cycles; a single word is sent with out_last=1.
- Assert start again during a dump of 0..31.
  -> ignored; exactly 32 words are delivered and one done pulse follows.
- Assert abort after the 3rd handshake of 0..31.
  -> next cycle: IDLE, out_valid=0, rf_sel=0, no done pulse; a fresh start then works normally.
- Pull rst_n low mid-SEND between clock edges.
  -> all outputs go to 0 immediately, asynchronously; after release the block sits idle until start.
